bh1750_i2c_target: RTL and testbench
====================================

// Module: bh1750_i2c_target
// PURPOSE
//  Synthesizable I2C target emulating the BH1750 ambient light sensor at the
//  far end of the bus from the BH1750 I2C master controller. Decodes
//  single-byte opcodes and runs a timed one-shot measurement that latches i_lux.
//  Returns the result as a 2-byte big-endian read.
//  Used as an on-FPGA sensor stand-in and as the bus model in master benches.
// PARAMETERS
//  P_ADDR         7'h23    7-bit target address (ADDR pin low)
//  P_MEAS_CYCLES  8000000  i_clk cycles from one-time-H opcode to result latch
// PORTS
//  i_clk        in     1   system clock, 50 MHz
//  i_rst        in     1   sync reset, active-low
//  io_sda       inout  1   open-drain SDA; drives only 0 or 1'bz
//  io_scl       inout  1   SCL; input only, never driven (no clock stretching)
//  i_lux        in     16  raw value captured at end of a measurement
//  o_opcode     out    8   last opcode byte received
//  o_cmd_stb    out    1   1-cycle pulse when o_opcode updates
//  o_powered    out    1   emulated power state
//  o_meas_busy  out    1   measurement timer running
//  o_data_reg   out    16  result register returned on reads
// BEHAVIOUR
//  Reset (i_rst==0, any state, including mid-transfer): io_sda=z, state IDLE,
//   o_opcode=0, o_cmd_stb=0, o_powered=0, o_meas_busy=0, o_data_reg=0,
//   timer=0.
//  Sync: SDA and SCL each pass a 2-flop synchronizer. Edges come from the
//   synced and the delayed synced copy.
//   START = SDA 1->0 while SCL=1. STOP = SDA 0->1 while SCL=1.
//  Bits are sampled on the synced SCL rising edge, MSB first.
//   io_sda output changes only on the synced SCL falling edge.
//  FSM: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX, TX_ACK, WAIT_STOP.
//   IDLE -START-> ADDR (bit count=0).
//   ADDR: shift 8 bits. If addr==P_ADDR, go to ADDR_ACK. Otherwise release
//    SDA and go to WAIT_STOP.
//   ADDR_ACK: drive 0 for the 9th clock. R/W=0 goes to CMD. R/W=1 loads the
//    shift register with o_data_reg[15:8] and goes to TX.
//   CMD: shift 8 bits, then go to CMD_ACK. Drive ACK 0 for the 9th clock.
//    On the ACK falling edge, update o_opcode, pulse o_cmd_stb, run the
//    opcode action, and go to WAIT_STOP.
//   TX: drive shift MSB (0 -> drive low, 1 -> z) for 8 clocks, then go to
//    TX_ACK with SDA released.
//   TX_ACK: sample the master bit on SCL rise.
//    ACK(0) after byte 0: load o_data_reg[7:0] and go to TX.
//    ACK(0) after byte 1 or later: load 8'hFF and go to TX.
//    NACK(1): go to WAIT_STOP.
//   WAIT_STOP: SDA released; wait for STOP (-> IDLE) or START (-> ADDR).
//  START or STOP in any non-IDLE state overrides the FSM.
//   START -> ADDR, STOP -> IDLE, SDA released that cycle.
//  Opcode actions (same cycle as o_cmd_stb):
//   8'h00  o_powered=0; abort timer, o_meas_busy=0
//   8'h01  o_powered=1
//   8'h07  if o_powered: o_data_reg=0; else ignored
//   8'h20  if o_powered: timer=0, o_meas_busy=1; else ignored
//   other  ACKed, stored in o_opcode, no action
//  Measurement timer: counts while o_meas_busy. At count P_MEAS_CYCLES-1:
//   o_data_reg<=i_lux, o_meas_busy=0, o_powered=0 (one-time auto power-down).
//   A new 8'h20 while busy restarts the timer from 0.
//  Reads during a measurement return the previous o_data_reg. The TX byte is
//   loaded at the ACK edge, so a latch mid-read does not corrupt it.
// TESTING
//  T1 reset: hold i_rst=0 mid-read -> SDA=z next cycle; all outputs at
//   reset values.
//  T2 write 0x46,0x01 -> ACK on both bytes; o_opcode=8'h01; one o_cmd_stb
//   pulse; o_powered=1.
//  T3 powered, write 0x20, i_lux=16'h1234 (P_MEAS_CYCLES=100) ->
//   o_meas_busy high 100 cycles; o_data_reg=16'h1234; o_powered=0.
//  T4 read 0x47, master ACK, NACK -> bytes 8'h12, 8'h34, SDA=z at STOP.
//   Third byte with ACK -> 8'hFF.
//  T5 address 0x5C (0x2E write) -> NACK (SDA=z); no o_cmd_stb; FSM IDLE
//   after STOP.
//  T6 unpowered 0x20 -> o_meas_busy stays 0.
//   Repeated START mid-CMD -> new ADDR accepted and ACKed.

Source files
------------

// File: rtl/bh1750_i2c_target_if.sv
// Sidecar bus between the BH1750 target emulation and its host logic.
// Latency: none, plain wires.
// Backpressure: none; status outputs are levels plus a single-cycle command strobe.
interface bh1750_i2c_target_if;
    logic [15:0] i_lux;
    logic [7:0]  o_opcode;
    logic        o_cmd_stb;
    logic        o_powered;
    logic        o_meas_busy;
    logic [15:0] o_data_reg;

    // Target side: consumes the lux sample and publishes the emulated sensor state.
    modport slave  (input  i_lux,
                    output o_opcode, o_cmd_stb, o_powered, o_meas_busy, o_data_reg);
    // Host side: supplies the lux sample and observes the sensor state.
    modport master (output i_lux,
                    input  o_opcode, o_cmd_stb, o_powered, o_meas_busy, o_data_reg);
endinterface

// File: rtl/bh1750_i2c_target.sv
// BH1750 ambient light sensor emulation as an I2C target: opcodes, timed one-shot, 2-byte read.
// Latency: 3 i_clk from bus edge to reaction (2-flop sync + edge register); result after P_MEAS_CYCLES.
// Backpressure: none; no clock stretching, the bus master must keep SCL phases above ~4 i_clk.
module bh1750_i2c_target #(
    parameter logic [6:0]  P_ADDR        = 7'h23,
    parameter int unsigned P_MEAS_CYCLES = 8000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    inout  wire                io_sda,
    inout  wire                io_scl,
    bh1750_i2c_target_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_CMD, S_CMD_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
    } state_t;

    localparam logic [31:0] LP_LAST = 32'(P_MEAS_CYCLES - 1);

    logic [1:0]  r_sda_sync, r_scl_sync;
    logic        r_sda_d, r_scl_d;
    state_t      r_state, w_state_nx;
    logic [3:0]  r_bit_cnt, w_bit_cnt_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic        r_byte1, w_byte1_nx;
    logic        r_sda_low, w_sda_low_nx;
    logic        w_cmd_fire;
    logic [7:0]  r_opcode;
    logic        r_cmd_stb, r_powered, r_meas_busy;
    logic [15:0] r_data_reg;
    logic [31:0] r_timer;
    logic        w_sda, w_scl, w_scl_rise, w_scl_fall, w_start, w_stop;

    // Open drain: only ever pull low, otherwise leave the line to the pull-up.
    assign io_sda = r_sda_low ? 1'b0 : 1'bz;

    assign w_sda      = r_sda_sync[1];
    assign w_scl      = r_scl_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    assign bus.o_opcode    = r_opcode;
    assign bus.o_cmd_stb   = r_cmd_stb;
    assign bus.o_powered   = r_powered;
    assign bus.o_meas_busy = r_meas_busy;
    assign bus.o_data_reg  = r_data_reg;

    // Bring SDA/SCL into i_clk and keep a delayed copy for edge detection; idle-high reset avoids false edges.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sda_sync <= 2'b11;
            r_scl_sync <= 2'b11;
            r_sda_d    <= 1'b1;
            r_scl_d    <= 1'b1;
        end else begin
            r_sda_sync <= {r_sda_sync[0], io_sda};
            r_scl_sync <= {r_scl_sync[0], io_scl};
            r_sda_d    <= r_sda_sync[1];
            r_scl_d    <= r_scl_sync[1];
        end
    end

    // Protocol FSM state and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'd0;
            r_byte1   <= 1'b0;
            r_sda_low <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_shift   <= w_shift_nx;
            r_byte1   <= w_byte1_nx;
            r_sda_low <= w_sda_low_nx;
        end
    end

    // Next-state logic: bits sampled on SCL rise, SDA changed only on SCL fall, START/STOP override.
    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt;
        w_shift_nx   = r_shift;
        w_byte1_nx   = r_byte1;
        w_sda_low_nx = r_sda_low;
        w_cmd_fire   = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_ADDR, S_CMD: begin
                if (w_scl_rise) begin
                    w_shift_nx   = {r_shift[6:0], w_sda};
                    w_bit_cnt_nx = r_bit_cnt + 4'd1;
                end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                    if (r_state == S_CMD) begin
                        w_sda_low_nx = 1'b1;
                        w_state_nx   = S_CMD_ACK;
                    end else if (r_shift[7:1] == P_ADDR) begin
                        w_sda_low_nx = 1'b1;
                        w_state_nx   = S_ADDR_ACK;
                    end else begin
                        w_sda_low_nx = 1'b0;
                        w_state_nx   = S_WAIT_STOP;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (w_scl_fall) begin
                    w_bit_cnt_nx = 4'd0;
                    w_byte1_nx   = 1'b0;
                    if (r_shift[0]) begin
                        // Read: first data bit goes out on the same fall that ends the ACK.
                        w_shift_nx   = r_data_reg[15:8];
                        w_sda_low_nx = ~r_data_reg[15];
                        w_state_nx   = S_TX;
                    end else begin
                        w_sda_low_nx = 1'b0;
                        w_state_nx   = S_CMD;
                    end
                end
            end
            S_CMD_ACK: begin
                if (w_scl_fall) begin
                    w_sda_low_nx = 1'b0;
                    w_cmd_fire   = 1'b1;
                    w_state_nx   = S_WAIT_STOP;
                end
            end
            S_TX: begin
                if (w_scl_rise) begin
                    w_bit_cnt_nx = r_bit_cnt + 4'd1;
                end else if (w_scl_fall) begin
                    if (r_bit_cnt == 4'd8) begin
                        w_sda_low_nx = 1'b0;
                        w_state_nx   = S_TX_ACK;
                    end else begin
                        w_sda_low_nx = ~r_shift[3'd7 - r_bit_cnt[2:0]];
                    end
                end
            end
            S_TX_ACK: begin
                if (w_scl_rise) begin
                    if (!w_sda) begin
                        // Byte is captured here so a result latch mid-read cannot tear it.
                        w_shift_nx   = r_byte1 ? 8'hFF : r_data_reg[7:0];
                        w_byte1_nx   = 1'b1;
                        w_bit_cnt_nx = 4'd0;
                        w_state_nx   = S_TX;
                    end else begin
                        w_state_nx   = S_WAIT_STOP;
                    end
                end
            end
            S_WAIT_STOP: ;
            default: w_state_nx = S_IDLE;
        endcase
        if (w_start) begin
            w_state_nx   = S_ADDR;
            w_bit_cnt_nx = 4'd0;
            w_sda_low_nx = 1'b0;
        end else if (w_stop && r_state != S_IDLE) begin
            w_state_nx   = S_IDLE;
            w_sda_low_nx = 1'b0;
        end
    end

    // Opcode execution, power state and one-shot measurement timer; a fresh command wins over expiry.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_opcode    <= 8'd0;
            r_cmd_stb   <= 1'b0;
            r_powered   <= 1'b0;
            r_meas_busy <= 1'b0;
            r_data_reg  <= 16'd0;
            r_timer     <= 32'd0;
        end else begin
            r_cmd_stb <= w_cmd_fire;
            if (r_meas_busy) begin
                if (r_timer == LP_LAST) begin
                    r_data_reg  <= bus.i_lux;
                    r_meas_busy <= 1'b0;
                    r_powered   <= 1'b0;
                    r_timer     <= 32'd0;
                end else begin
                    r_timer <= r_timer + 32'd1;
                end
            end
            if (w_cmd_fire) begin
                r_opcode <= r_shift;
                case (r_shift)
                    8'h00: begin
                        r_powered   <= 1'b0;
                        r_meas_busy <= 1'b0;
                        r_timer     <= 32'd0;
                    end
                    8'h01: r_powered <= 1'b1;
                    8'h07: if (r_powered) r_data_reg <= 16'd0;
                    8'h20: if (r_powered) begin
                        r_timer     <= 32'd0;
                        r_meas_busy <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bh1750_i2c_target.sv
// Directed bench for the BH1750 target: bit-banged I2C master, scoreboard of expected ACK/data bytes.
// Latency: bus half period of 10 clocks leaves margin over the target's synchronizer delay.
// Backpressure: none; the bench never waits on the DUT, every step is a fixed cycle count.
module tb_bh1750_i2c_target;
    localparam int H = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic m_sda_low = 1'b0;
    logic m_scl = 1'b1;
    wire  sda;
    wire  scl;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;
    assign scl = m_scl;

    bh1750_i2c_target_if ifc ();

    bh1750_i2c_target #(.P_ADDR(7'h23), .P_MEAS_CYCLES(100)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_sda(sda),
        .io_scl(scl),
        .bus   (ifc)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int stb_cnt = 0;
    int busy_cyc = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        if (ifc.o_cmd_stb)   stb_cnt  <= stb_cnt + 1;
        if (ifc.o_meas_busy) busy_cyc <= busy_cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_bad++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; cyc(H);
        m_scl = 1'b1;     cyc(H);
        m_sda_low = 1'b1; cyc(H);
        m_scl = 1'b0;     cyc(H);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; cyc(H);
        m_scl = 1'b1;     cyc(H);
        m_sda_low = 1'b0; cyc(H);
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b; cyc(H);
        m_scl = 1'b1;   cyc(H);
        m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda_low = 1'b0; cyc(H);
        m_scl = 1'b1;     cyc(H / 2);
        ack = sda;        cyc(H / 2);
        m_scl = 1'b0;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        d = 8'd0;
        m_sda_low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(H);
            m_scl = 1'b1; cyc(H / 2);
            d = {d[6:0], sda};
            cyc(H / 2);
            m_scl = 1'b0;
        end
        m_sda_low = ~nack; cyc(H);
        m_scl = 1'b1;      cyc(H);
        m_scl = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [7:0] b, input logic exp_ack);
        logic a;
        exp_q.push_back({7'd0, exp_ack});
        write_byte(b, a);
        sb_check(tag, {7'd0, a});
    endtask

    task automatic rd(input string tag, input logic nack, input logic [7:0] exp_d);
        logic [7:0] d;
        exp_q.push_back(exp_d);
        read_byte(nack, d);
        sb_check(tag, d);
    endtask

    initial begin
        int s0;
        int b0;
        ifc.i_lux = 16'h0000;

        // Power-on reset values.
        cyc(5);
        chk("rst_sda", {15'd0, sda}, 16'd1);
        chk("rst_opcode", {8'd0, ifc.o_opcode}, 16'h0000);
        chk("rst_stb", {15'd0, ifc.o_cmd_stb}, 16'd0);
        chk("rst_powered", {15'd0, ifc.o_powered}, 16'd0);
        chk("rst_busy", {15'd0, ifc.o_meas_busy}, 16'd0);
        chk("rst_data", ifc.o_data_reg, 16'h0000);
        rst = 1'b1;
        cyc(5);

        // Power on.
        s0 = stb_cnt;
        i2c_start();
        wr("t2_addr_ack", 8'h46, 1'b0);
        wr("t2_cmd_ack", 8'h01, 1'b0);
        i2c_stop();
        cyc(5);
        chk("t2_opcode", {8'd0, ifc.o_opcode}, 16'h0001);
        chk("t2_stb_count", 16'(stb_cnt - s0), 16'd1);
        chk("t2_powered", {15'd0, ifc.o_powered}, 16'd1);

        // One-shot measurement.
        ifc.i_lux = 16'h1234;
        b0 = busy_cyc;
        i2c_start();
        wr("t3_addr_ack", 8'h46, 1'b0);
        wr("t3_cmd_ack", 8'h20, 1'b0);
        i2c_stop();
        chk("t3_busy_mid", {15'd0, ifc.o_meas_busy}, 16'd1);
        chk("t3_data_before", ifc.o_data_reg, 16'h0000);
        cyc(150);
        chk("t3_busy_cycles", 16'(busy_cyc - b0), 16'd100);
        chk("t3_data", ifc.o_data_reg, 16'h1234);
        chk("t3_powered_off", {15'd0, ifc.o_powered}, 16'd0);
        chk("t3_busy_end", {15'd0, ifc.o_meas_busy}, 16'd0);
        ifc.i_lux = 16'hBEEF;

        // Two-byte read, NACK on the second byte.
        i2c_start();
        wr("t4_addr_ack", 8'h47, 1'b0);
        rd("t4_byte0", 1'b0, 8'h12);
        rd("t4_byte1", 1'b1, 8'h34);
        cyc(5);
        chk("t4_sda_released", {15'd0, sda}, 16'd1);
        i2c_stop();
        chk("t4_sda_stop", {15'd0, sda}, 16'd1);

        // Three-byte read: bytes beyond the result return 0xFF.
        i2c_start();
        wr("t4b_addr_ack", 8'h47, 1'b0);
        rd("t4b_byte0", 1'b0, 8'h12);
        rd("t4b_byte1", 1'b0, 8'h34);
        rd("t4b_byte2", 1'b1, 8'hFF);
        i2c_stop();

        // Foreign address is not acknowledged.
        s0 = stb_cnt;
        i2c_start();
        wr("t5_addr_nack", 8'h5C, 1'b1);
        i2c_stop();
        cyc(5);
        chk("t5_stb_count", 16'(stb_cnt - s0), 16'd0);
        chk("t5_state_idle", {13'd0, dut.r_state}, 16'd0);

        // Measure while unpowered is ignored but still recorded.
        s0 = stb_cnt;
        b0 = busy_cyc;
        i2c_start();
        wr("t6_addr_ack", 8'h46, 1'b0);
        wr("t6_cmd_ack", 8'h20, 1'b0);
        i2c_stop();
        cyc(5);
        chk("t6_busy", {15'd0, ifc.o_meas_busy}, 16'd0);
        chk("t6_busy_cycles", 16'(busy_cyc - b0), 16'd0);
        chk("t6_opcode", {8'd0, ifc.o_opcode}, 16'h0020);
        chk("t6_stb_count", 16'(stb_cnt - s0), 16'd1);

        // Repeated START in the middle of a command byte.
        i2c_start();
        wr("t6r_addr_ack", 8'h46, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        i2c_start();
        wr("t6r_addr2_ack", 8'h46, 1'b0);
        wr("t6r_cmd_ack", 8'h01, 1'b0);
        i2c_stop();
        cyc(5);
        chk("t6r_powered", {15'd0, ifc.o_powered}, 16'd1);
        chk("t6r_opcode", {8'd0, ifc.o_opcode}, 16'h0001);

        // Reset in the middle of a read while the target pulls SDA low.
        i2c_start();
        wr("t1_addr_ack", 8'h47, 1'b0);
        cyc(5);
        chk("t1_sda_driven", {15'd0, sda}, 16'd0);
        rst = 1'b0;
        cyc(1);
        chk("t1_sda_released", {15'd0, sda}, 16'd1);
        chk("t1_opcode", {8'd0, ifc.o_opcode}, 16'h0000);
        chk("t1_powered", {15'd0, ifc.o_powered}, 16'd0);
        chk("t1_busy", {15'd0, ifc.o_meas_busy}, 16'd0);
        chk("t1_data", ifc.o_data_reg, 16'h0000);
        chk("t1_stb", {15'd0, ifc.o_cmd_stb}, 16'd0);
        chk("t1_state", {13'd0, dut.r_state}, 16'd0);
        rst = 1'b1;
        cyc(3);
        i2c_stop();
        cyc(5);
        chk("t1_state_after", {13'd0, dut.r_state}, 16'd0);
        chk("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
